inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage of the single-cycle MIPS core.
- Sits directly upstream of the opcode control decoder.
- Holds the PC and fetches one instruction word at a time from instruction memory over a req/ack handshake.
- Presents the instruction to the decode/execute stage and computes the next PC from the decoder's Branch/Equal/Jump outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0040_0000, PC after reset; must be word aligned.
TIMEOUT, 16, max cycles imem_req may stay high without imem_ack before a fetch error; legal range 1..255.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  memory returns data this cycle; honoured only while imem_req=1
imem_rdata  in  32  instruction word, valid with imem_ack
ins_valid  out  1  ins/pc_out hold a valid instruction
ins  out  32  current instruction; ins[31:26] feeds the decoder opcode
pc_out  out  32  address of ins
pc_plus4  out  32  pc_out + 4 (combinational)
ins_ready  in  1  downstream retires ins this cycle
branch  in  1  decoder Branch, sampled at retire
equal  in  1  decoder Equal (1=beq, 0=bne), sampled at retire
jump  in  1  decoder Jump, sampled at retire
alu_zero  in  1  ALU zero flag, sampled at retire
fetch_err  out  1  sticky fetch-timeout error

Behaviour:
- FSM states: REQ, HOLD, ERR.
- Reset (rst=1 at edge, overrides everything incl. same-cycle ack/ready):
  - state=REQ, pc=RESET_PC, ins=0, ins_valid=0, fetch_err=0, timeout counter=0.
  - imem_req is combinational from state: 1 in REQ, so it is 1 in the first cycle after reset.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack (same-cycle ack allowed): ins<=imem_rdata, ins_valid<=1, counter<=0, go HOLD.
  - Else counter++. When counter reaches TIMEOUT-1 without ack: go ERR, fetch_err<=1.
  - ins_ready ignored in REQ.
- HOLD:
  - imem_req=0, ins_valid=1; ins and pc_out stable.
  - On ins_ready: pc<=next_pc, ins_valid<=0, go REQ.
  - imem_ack ignored in HOLD.
- ERR:
  - imem_req=0, ins_valid=0, fetch_err=1; exit only via rst.
- next_pc, evaluated at retire, 32-bit, wraps modulo 2^32:
  - jump=1: {pc_plus4[31:28], ins[25:0], 2'b00}. Jump has priority over branch.
  - else branch=1 and (equal ? alu_zero : ~alu_zero): pc_plus4 + ({{14{ins[15]}}, ins[15:0], 2'b00}).
  - else: pc_plus4.
- pc[1:0] always 00 by construction.
- Throughput: minimum 2 cycles per instruction (REQ with immediate ack, then HOLD with immediate ready).
- Memory shares rst, so no stale ack after reset. An ack arriving during HOLD/ERR is a memory protocol violation; it is dropped.

Optional Feature:
Macro INST_FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt (32) and stall_cnt (32), both 0 on reset.
  - fetch_cnt increments on each accepted imem_ack.
  - stall_cnt increments each REQ cycle without ack.
  - Both wrap at 2^32.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Reset release, RESET_PC=0x00400000:
   - Next cycle imem_req=1, imem_addr=0x00400000.
   - Immediate ack with 0x20080005 -> following cycle ins_valid=1, ins=0x20080005, pc_out=0x00400000, pc_plus4=0x00400004.
2. Sequential retire: ins_ready=1, branch=jump=0 -> ins_valid=0, then imem_addr=0x00400004. Hold ins_ready=0 for 5 cycles in HOLD -> ins/pc_out unchanged.
3. Branches at pc=0x00400008, ins=0x1000FFFF:
   - branch=1, equal=1, alu_zero=1 -> next imem_addr=0x00400008.
   - Same with equal=0 (bne, zero=1) -> 0x0040000C.
   - equal=0, alu_zero=0 -> 0x00400008.
4. Jump at pc=0x00400010, ins=0x08100000, jump=1, branch=1, equal=1, alu_zero=1 -> next imem_addr=0x00400000 (jump wins).
5. Handshake with TIMEOUT=4:
   - Ack after 3 REQ cycles -> req held high, ins_valid=0 until capture.
   - No ack -> fetch_err=1 and imem_req=0 after 4th REQ cycle, stays until rst.
   - With INST_FETCH_PERF_CNT_EN: stall_cnt=3 after the delayed fetch.
6. rst=1 in HOLD with ins_ready=1, and separately in REQ with imem_ack=1 -> next edge ins_valid=0, ins=0, pc=RESET_PC, fetch_err=0.

Source files
------------

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction memory request/ack bus
// Ports (signals):
//   imem_req   fetch request, driven by the fetch stage
//   imem_addr  word-aligned fetch address
//   imem_ack   memory returns data this cycle
//   imem_rdata instruction word, valid with imem_ack
// Modports: master = fetch stage, slave = instruction memory.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - MIPS instruction fetch stage with PC and next-PC logic
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem            instruction memory bus (inst_fetch_if.master)
//   ins_valid       ins/pc_out hold a valid instruction
//   ins, pc_out     current instruction and its address
//   pc_plus4        pc_out + 4
//   ins_ready       downstream retires ins this cycle
//   branch, equal, jump, alu_zero   next-PC controls sampled at retire
//   fetch_err       sticky fetch-timeout error
// Optional macro INST_FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt outputs.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master imem,
  output logic         ins_valid,
  output logic [31:0]  ins,
  output logic [31:0]  pc_out,
  output logic [31:0]  pc_plus4,
  input  logic         ins_ready,
  input  logic         branch,
  input  logic         equal,
  input  logic         jump,
  input  logic         alu_zero,
  output logic         fetch_err
`ifdef INST_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_cnt,
  output logic [31:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Counter value seen in the last REQ cycle that may still wait for an ack.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic        ins_valid_q, ins_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] pc_inc;
  logic [31:0] branch_off;
  logic [31:0] next_pc;
  logic        branch_taken;

`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
`endif

  assign pc_inc       = pc_q + 32'd4;
  assign branch_off   = {{14{ins_q[15]}}, ins_q[15:0], 2'b00};
  // equal selects beq (taken on zero) versus bne (taken on non-zero).
  assign branch_taken = branch && (equal ? alu_zero : ~alu_zero);

  always_comb begin
    next_pc = pc_inc;
    if (jump) begin
      next_pc = {pc_inc[31:28], ins_q[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_inc + branch_off;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    fetch_err_d = fetch_err_q;
    cnt_d       = cnt_q;
`ifdef INST_FETCH_PERF_CNT_EN
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
`endif
    case (state_q)
      REQ: begin
        if (imem.imem_ack) begin
          ins_d       = imem.imem_rdata;
          ins_valid_d = 1'b1;
          cnt_d       = 8'd0;
          state_d     = HOLD;
`ifdef INST_FETCH_PERF_CNT_EN
          fetch_cnt_d = fetch_cnt_q + 32'd1;
`endif
        end else begin
`ifdef INST_FETCH_PERF_CNT_EN
          stall_cnt_d = stall_cnt_q + 32'd1;
`endif
          // An ack in the last allowed cycle still wins over the timeout.
          if (cnt_q == TIMEOUT_LAST) begin
            state_d     = ERR;
            fetch_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (ins_ready) begin
          pc_d        = next_pc;
          ins_valid_d = 1'b0;
          state_d     = REQ;
        end
      end
      ERR: begin
        ins_valid_d = 1'b0;
        fetch_err_d = 1'b1;
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      ins_q       <= 32'd0;
      ins_valid_q <= 1'b0;
      fetch_err_q <= 1'b0;
      cnt_q       <= 8'd0;
`ifdef INST_FETCH_PERF_CNT_EN
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      fetch_err_q <= fetch_err_d;
      cnt_q       <= cnt_d;
`ifdef INST_FETCH_PERF_CNT_EN
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign ins_valid      = ins_valid_q;
  assign ins            = ins_q;
  assign pc_out         = pc_q;
  assign pc_plus4       = pc_inc;
  assign fetch_err      = fetch_err_q;
`ifdef INST_FETCH_PERF_CNT_EN
  assign fetch_cnt      = fetch_cnt_q;
  assign stall_cnt      = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        ins_ready;
  logic        branch;
  logic        equal;
  logic        jump;
  logic        alu_zero;
  logic        fetch_err;
`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  inst_fetch_if imem_if ();

  inst_fetch #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem      (imem_if),
    .ins_valid (ins_valid),
    .ins       (ins),
    .pc_out    (pc_out),
    .pc_plus4  (pc_plus4),
    .ins_ready (ins_ready),
    .branch    (branch),
    .equal     (equal),
    .jump      (jump),
    .alu_zero  (alu_zero),
    .fetch_err (fetch_err)
`ifdef INST_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        br;
    logic        eq;
    logic        jmp;
    logic        zero;
    int          hold;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ins_valid"}, {31'd0, ins_valid}, 32'd0);
    chk({tag, " ins"}, ins, 32'd0);
    chk({tag, " pc_out"}, pc_out, RST_PC);
    chk({tag, " fetch_err"}, {31'd0, fetch_err}, 32'd0);
    chk({tag, " imem_req"}, {31'd0, imem_if.imem_req}, 32'd1);
    chk({tag, " imem_addr"}, imem_if.imem_addr, RST_PC);
  endtask

  initial begin
    //          rdata          br    eq    jmp   zero  hold exp_pc         exp_next
    vecs[0]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0040_0000, 32'h0040_0004};
    vecs[1]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 32'h0040_0004, 32'h0040_0008};
    vecs[2]  = '{32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 0, 32'h0040_0008, 32'h0040_0008};
    vecs[3]  = '{32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0040_0008, 32'h0040_0008};
    vecs[4]  = '{32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1, 32'h0040_0008, 32'h0040_000C};
    vecs[5]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h0040_000C, 32'h0040_0010};
    vecs[6]  = '{32'h0810_0000, 1'b1, 1'b1, 1'b1, 1'b1, 0, 32'h0040_0010, 32'h0040_0000};
    vecs[7]  = '{32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0040_0000, 32'h0FFF_FFFC};
    vecs[8]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0FFF_FFFC, 32'h1000_0000};
    vecs[9]  = '{32'h0800_0000, 1'b0, 1'b0, 1'b1, 1'b0, 2, 32'h1000_0000, 32'h1000_0000};
    vecs[10] = '{32'h1000_8000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 32'h1000_0000, 32'h0FFE_0004};

    rst = 1'b1;
    ins_ready = 1'b0;
    branch = 1'b0;
    equal = 1'b0;
    jump = 1'b0;
    alu_zero = 1'b0;
    imem_if.imem_ack = 1'b0;
    imem_if.imem_rdata = 32'd0;
    step();
    step();
    chk_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      chk($sformatf("v%0d req", i), {31'd0, imem_if.imem_req}, 32'd1);
      chk($sformatf("v%0d addr", i), imem_if.imem_addr, vecs[i].exp_pc);
      imem_if.imem_ack = 1'b1;
      imem_if.imem_rdata = vecs[i].rdata;
      step();
      imem_if.imem_ack = 1'b0;
      chk($sformatf("v%0d valid", i), {31'd0, ins_valid}, 32'd1);
      chk($sformatf("v%0d req_low", i), {31'd0, imem_if.imem_req}, 32'd0);
      chk($sformatf("v%0d ins", i), ins, vecs[i].rdata);
      chk($sformatf("v%0d pc_out", i), pc_out, vecs[i].exp_pc);
      chk($sformatf("v%0d pc_plus4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
      // Stray acks while holding must not disturb the held instruction.
      for (int h = 0; h < vecs[i].hold; h++) begin
        imem_if.imem_ack = 1'b1;
        imem_if.imem_rdata = 32'hDEAD_BEEF;
        step();
        chk($sformatf("v%0d hold%0d ins", i, h), ins, vecs[i].rdata);
        chk($sformatf("v%0d hold%0d pc", i, h), pc_out, vecs[i].exp_pc);
        chk($sformatf("v%0d hold%0d valid", i, h), {31'd0, ins_valid}, 32'd1);
      end
      imem_if.imem_ack = 1'b0;
      ins_ready = 1'b1;
      branch = vecs[i].br;
      equal = vecs[i].eq;
      jump = vecs[i].jmp;
      alu_zero = vecs[i].zero;
      step();
      ins_ready = 1'b0;
      branch = 1'b0;
      equal = 1'b0;
      jump = 1'b0;
      alu_zero = 1'b0;
      chk($sformatf("v%0d retired", i), {31'd0, ins_valid}, 32'd0);
      chk($sformatf("v%0d next_addr", i), imem_if.imem_addr, vecs[i].exp_next);
    end

    // Delayed ack: three idle REQ cycles (ins_ready ignored), ack in the fourth.
    ins_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("dly%0d req", c), {31'd0, imem_if.imem_req}, 32'd1);
      chk($sformatf("dly%0d valid", c), {31'd0, ins_valid}, 32'd0);
      chk($sformatf("dly%0d addr", c), imem_if.imem_addr, 32'h0FFE_0004);
    end
    ins_ready = 1'b0;
    imem_if.imem_ack = 1'b1;
    imem_if.imem_rdata = 32'h1234_5678;
    step();
    imem_if.imem_ack = 1'b0;
    chk("dly captured valid", {31'd0, ins_valid}, 32'd1);
    chk("dly captured ins", ins, 32'h1234_5678);
    chk("dly no err", {31'd0, fetch_err}, 32'd0);
`ifdef INST_FETCH_PERF_CNT_EN
    chk("perf stall_cnt", stall_cnt, 32'd3);
    chk("perf fetch_cnt", fetch_cnt, 32'd12);
`endif

    // Reset while holding, with a same-cycle retire.
    rst = 1'b1;
    ins_ready = 1'b1;
    jump = 1'b1;
    step();
    rst = 1'b0;
    ins_ready = 1'b0;
    jump = 1'b0;
    chk_reset_state("rst_hold");
`ifdef INST_FETCH_PERF_CNT_EN
    chk("rst_hold fetch_cnt", fetch_cnt, 32'd0);
`endif

    // Reset while requesting, with a same-cycle ack.
    rst = 1'b1;
    imem_if.imem_ack = 1'b1;
    imem_if.imem_rdata = 32'hCAFE_F00D;
    step();
    rst = 1'b0;
    imem_if.imem_ack = 1'b0;
    chk_reset_state("rst_req");

    // Timeout: no ack for four REQ cycles.
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("to%0d req", c), {31'd0, imem_if.imem_req}, 32'd1);
      chk($sformatf("to%0d err", c), {31'd0, fetch_err}, 32'd0);
    end
    step();
    chk("to err set", {31'd0, fetch_err}, 32'd1);
    chk("to req low", {31'd0, imem_if.imem_req}, 32'd0);
    chk("to valid low", {31'd0, ins_valid}, 32'd0);
`ifdef INST_FETCH_PERF_CNT_EN
    chk("to stall_cnt", stall_cnt, 32'd4);
`endif
    // Error is sticky against ack and ready.
    imem_if.imem_ack = 1'b1;
    ins_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("err%0d sticky", c), {31'd0, fetch_err}, 32'd1);
      chk($sformatf("err%0d req", c), {31'd0, imem_if.imem_req}, 32'd0);
      chk($sformatf("err%0d valid", c), {31'd0, ins_valid}, 32'd0);
    end
    imem_if.imem_ack = 1'b0;
    ins_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("rst_err");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
